option22_loader: RTL and testbench

OPTION22_LOADER -- requirements
Module: option22_loader

---
 rtl/option22_loader_if.sv | 10 +
 rtl/option22_loader.sv | 121 ++++++++++++
 tb/tb_option22_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/option22_loader_if.sv
// Producer byte stream into the option22 loader.
// byte_in is taken only on a cycle where byte_valid and byte_ready are both high.
interface option22_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/option22_loader.sv
// Serially loads producer bytes into chosen slots of a circulating 8-bit-slot shift buffer.
// A byte is accepted on the last bit cycle before its slot and written MSB first over the next 8 cycles; a missed slot waits one revolution.
module option22_loader #(
  parameter int WORD_COUNT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       start_slot,
  input  logic [6:0]       length,
  option22_loader_if.slave src,
  output logic             write,
  output logic             din,
  output logic             busy,
  output logic             done,
  output logic [5:0]       slot_pos
);
  localparam int AW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [6:0]    MAX_LEN  = 7'(WORD_COUNT);
  localparam logic [AW-1:0] SLOT_ONE = AW'(1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [AW-1:0] slot_cnt;
  logic [AW-1:0] tgt_slot;
  logic [6:0]    remain;
  logic [7:0]    shift_reg;
  logic          wr_active;
  logic          done_q;
  logic          ready_int;
  logic [6:0]    len_clamped;
  logic          last_bit;
  logic          accept;
  logic          finish;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign last_bit    = (bit_cnt == 3'd7);
  assign accept      = ready_int & src.byte_valid;
  assign finish      = wr_active & last_bit & (remain == 7'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len_clamped != 7'd0) state_nxt = LOAD;
      LOAD:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready only on the final bit of the slot just before the target slot.
  always_comb begin
    busy      = 1'b0;
    ready_int = 1'b0;
    case (state)
      LOAD: begin
        busy      = 1'b1;
        ready_int = last_bit && (slot_cnt == tgt_slot - SLOT_ONE) && (remain != 7'd0);
      end
      default: ;
    endcase
  end

  // Free-running ring position; clears with the target so both stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      slot_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (last_bit) slot_cnt <= slot_cnt + SLOT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_slot  <= '0;
      remain    <= 7'd0;
      shift_reg <= 8'd0;
      wr_active <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          wr_active <= 1'b0;
          if (start) begin
            tgt_slot <= start_slot[AW-1:0];
            remain   <= len_clamped;
            done_q   <= (len_clamped == 7'd0);
          end
        end
        LOAD: begin
          // Accepting on bit 7 lets the next byte follow the current one without a gap.
          if (accept) begin
            shift_reg <= src.byte_in;
            tgt_slot  <= tgt_slot + SLOT_ONE;
            remain    <= remain - 7'd1;
            wr_active <= 1'b1;
          end else if (last_bit) begin
            wr_active <= 1'b0;
          end
          if (finish) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign src.byte_ready = ready_int;
  assign write          = wr_active;
  assign din            = wr_active & shift_reg[3'd7 - bit_cnt];
  assign done           = done_q;
  assign slot_pos       = 6'(slot_cnt);
endmodule

// File: tb/tb_option22_loader.sv
// Bench for option22_loader: per-cycle comparison against a slot-timing model plus an emulated target ring.
`timescale 1ns/1ps
module tb_option22_loader;
  localparam int WC = 64;
  localparam int W  = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] start_slot = 6'd0;
  logic [6:0] length = 7'd0;
  logic       write, din, busy, done;
  logic [5:0] slot_pos;

  option22_loader_if bus();

  option22_loader #(.WORD_COUNT(WC)) dut (
    .clk(clk), .reset(reset), .start(start), .start_slot(start_slot), .length(length),
    .src(bus.slave), .write(write), .din(din), .busy(busy), .done(done), .slot_pos(slot_pos)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] ring [WC];
  logic [7:0] dat [WC];
  bit         valid_arr [W];
  logic [4:0] exp_vec [W];   // {ready, write, din, busy, done}
  int         obs_ready_q[$];
  int         obs_done_cyc, obs_done_cnt, obs_acc_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    foreach (ring[i]) ring[i] = 8'd0;
  endtask

  // mode 0: producer always valid; 1: random misses; 2: valid low up to and including the first opportunity
  task automatic run_load(input int ss, input int len, input int mode, input int miss_pct,
                          input bit fixed, input int extra_rel, input int abort_rel);
    int t0, lc, c, misses, last_acc, end_rel, nxt, prev;
    logic [7:0] ring_exp [WC];
    t0 = cyc;
    lc = (len > WC) ? WC : len;
    for (int k = 0; k < WC; k++) dat[k] = fixed ? ((k == 0) ? 8'hA5 : 8'h3C) : 8'($urandom);
    for (int r = 0; r < W; r++) begin
      valid_arr[r] = (mode == 0) ? 1'b1 : ($urandom_range(99) >= miss_pct);
      exp_vec[r]   = 5'd0;
    end
    if (mode == 2) begin
      c = t0 + 1;
      prev = (ss % WC + WC - 1) % WC;
      while (!(c % 8 == 7 && (c / 8) % WC == prev)) c++;
      for (int r = 0; r < W; r++) valid_arr[r] = (t0 + r > c);
    end

    // Byte k lands in slot ss+k; its chance is bit 7 of the preceding slot, repeating every revolution.
    c = t0 + 1; misses = 0; last_acc = t0;
    for (int k = 0; k < lc; k++) begin
      prev = (ss % WC + k + WC - 1) % WC;
      while (!(c % 8 == 7 && (c / 8) % WC == prev)) c++;
      while (!valid_arr[c - t0]) begin
        if (mode == 1 && misses >= 2) valid_arr[c - t0] = 1'b1;
        else begin
          exp_vec[c - t0][4] = 1'b1;
          misses++;
          c += 8 * WC;
        end
      end
      exp_vec[c - t0][4] = 1'b1;
      for (int b = 0; b < 8; b++) begin
        exp_vec[c - t0 + 1 + b][3] = 1'b1;
        exp_vec[c - t0 + 1 + b][2] = dat[k][7 - b];
      end
      last_acc = c;
      c++;
    end
    if (lc == 0) end_rel = 1;
    else begin
      for (int r = 1; r <= last_acc - t0 + 8; r++) exp_vec[r][1] = 1'b1;
      end_rel = last_acc - t0 + 9;
    end
    exp_vec[end_rel][0] = 1'b1;
    for (int i = 0; i < WC; i++) ring_exp[i] = ring[i];
    for (int k = 0; k < lc; k++) ring_exp[(ss + k) % WC] = dat[k];

    obs_ready_q.delete(); obs_done_cnt = 0; obs_done_cyc = -1; obs_acc_cnt = 0; nxt = 0;
    for (int r = 0; r <= end_rel + 2; r++) begin
      if (r == abort_rel) begin
        reset = 1'b1; start = 1'b0; bus.byte_valid = 1'b0;
        step();
        check("abort outputs", {21'd0, bus.byte_ready, write, din, busy, done, slot_pos}, 32'd0);
        reset = 1'b0;
        cyc = 0;
        foreach (ring[i]) ring[i] = 8'd0;
        return;
      end
      start          = (r == 0) || (r == extra_rel);
      start_slot     = (r == extra_rel) ? 6'd5 : 6'(ss);
      length         = (r == extra_rel) ? 7'd1 : 7'(len);
      bus.byte_valid = valid_arr[r];
      bus.byte_in    = (nxt < lc) ? dat[nxt] : 8'($urandom);
      check($sformatf("cyc%0d ready/write/din/busy/done/slot", cyc),
            {21'd0, bus.byte_ready, write, din, busy, done, slot_pos},
            {21'd0, exp_vec[r], 6'((cyc / 8) % WC)});
      if (bus.byte_ready) obs_ready_q.push_back(cyc);
      if (bus.byte_ready && bus.byte_valid) begin obs_acc_cnt++; nxt++; end
      if (done) begin obs_done_cnt++; obs_done_cyc = cyc; end
      if (write) ring[(cyc / 8) % WC][7 - (cyc % 8)] = din;
      step();
    end
    start = 1'b0;
    bus.byte_valid = 1'b0;
    for (int i = 0; i < WC; i++) check($sformatf("ring slot %0d", i), 32'(ring[i]), 32'(ring_exp[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state, then the reference two-byte load starting at cycle 2.
    do_reset();
    check("reset state", {21'd0, bus.byte_ready, write, din, busy, done, slot_pos}, 32'd0);
    step(); step();
    run_load(1, 2, 0, 0, 1'b1, -1, -1);
    check("t1 ready count", obs_ready_q.size(), 2);
    check("t1 ready0 cycle", (obs_ready_q.size() > 0) ? obs_ready_q[0] : -1, 7);
    check("t1 ready1 cycle", (obs_ready_q.size() > 1) ? obs_ready_q[1] : -1, 15);
    check("t1 done cycle", obs_done_cyc, 24);

    // Producer misses the first slot opportunity.
    do_reset();
    step(); step();
    run_load(1, 2, 2, 0, 1'b1, -1, -1);
    check("t2 first ready", (obs_ready_q.size() > 0) ? obs_ready_q[0] : -1, 7);
    check("t2 retry ready", (obs_ready_q.size() > 1) ? obs_ready_q[1] : -1, 7 + 8 * WC);
    check("t2 slot1 byte", 32'(ring[1]), 32'h A5);

    // Full-ring load wrapping from the last slot to slot 0.
    run_load(WC - 1, WC, 0, 0, 1'b0, -1, -1);
    check("t3 accepted", obs_acc_cnt, WC);
    check("t3 done count", obs_done_cnt, 1);
    check("t3 first byte slot", 32'(ring[WC - 1]), 32'(dat[0]));

    // Zero-length request.
    t = cyc;
    run_load(7, 0, 0, 0, 1'b0, -1, -1);
    check("t4 done cycle", obs_done_cyc, t + 1);
    check("t4 ready count", obs_ready_q.size(), 0);

    // Reset mid-byte, then a fresh load.
    do_reset();
    step(); step();
    run_load(3, 4, 0, 0, 1'b0, -1, 25);
    run_load(10, 3, 1, 20, 1'b0, -1, -1);
    check("t5 done count", obs_done_cnt, 1);

    // Oversized length with a second start while busy.
    run_load(20, 100, 0, 0, 1'b0, 100, -1);
    check("t6 accepted", obs_acc_cnt, WC);
    check("t6 done count", obs_done_cnt, 1);

    // Random slots, lengths and producer gaps.
    for (int i = 0; i < 6; i++) begin
      run_load(int'($urandom_range(WC - 1)), int'($urandom_range(12)), 1, 25, 1'b0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
